// File: rtl/uart_rx_controller.sv
// UART receive FSM driven by an external edge/bit counter; 2-of-3 majority sampling, registered result/error pulses.
// Latency: data_valid one cycle after the stop-bit eob; no backpressure, so every received byte must be consumed on the pulse.
module uart_rx_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [7:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [15:0]           edge_count,
    input  logic [3:0]            bit_count,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);
    localparam logic [3:0] MAX_BIT  = 4'd10;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [DATA_WIDTH-1:0] sr;
    logic [2:0]            smp;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic [15:0]           ps;
    logic [15:0]           mid;
    logic                  eob;
    logic                  bit_s;
    logic                  par_exp;

    assign ps      = {8'd0, prescale};
    assign mid     = {9'd0, prescale[7:1]};
    assign eob     = (edge_count == ps - 16'd1);
    assign bit_s   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign par_exp = (^sr) ^ par_typ_q;

    assign busy       = (state != S_IDLE);
    assign cnt_enable = (state == S_START) || (state == S_DATA) ||
                        (state == S_PARITY) || (state == S_STOP);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!rx_in) state_nx = S_START;
            S_START:  if (eob) state_nx = bit_s ? S_IDLE : S_DATA;
            S_DATA:   if (eob && bit_count == LAST_BIT) state_nx = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (eob) state_nx = S_STOP;
            S_STOP:   if (eob) state_nx = (bit_s && !par_bad) ? S_DONE : S_IDLE;
            S_DONE:   state_nx = rx_in ? S_IDLE : S_START;
            default:  state_nx = S_IDLE;
        endcase
        // A runaway bit index means prescale was abused mid-frame; abandon the frame.
        if (cnt_enable && bit_count > MAX_BIT) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            sr          <= '0;
            p_data      <= '0;
            smp         <= 3'b000;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            par_bad     <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            state       <= state_nx;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;

            if (cnt_enable) begin
                if (edge_count == mid - 16'd1) smp[0] <= rx_in;
                if (edge_count == mid)         smp[1] <= rx_in;
                if (edge_count == mid + 16'd1) smp[2] <= rx_in;
            end

            if (state_nx == S_START) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_bad   <= 1'b0;
            end

            if (eob) begin
                case (state)
                    S_START:  if (bit_s) strt_glitch <= 1'b1;
                    S_DATA:   sr <= {bit_s, sr[DATA_WIDTH-1:1]};
                    S_PARITY: if (bit_s != par_exp) begin
                        par_err <= 1'b1;
                        par_bad <= 1'b1;
                    end
                    S_STOP: begin
                        if (!bit_s) begin
                            stp_err <= 1'b1;
                        end else if (!par_bad) begin
                            data_valid <= 1'b1;
                            p_data     <= sr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
